// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: in-order issue controller between decode and the even/odd execution pipes.
//
// Accepts one decoded instruction pair per in_valid/in_ready handshake and holds it in two
// slots. Each cycle it decides whether slot 1 and/or slot 2 can issue. The check uses a
// per-register countdown scoreboard (RAW/WAW) and an intra-pair dependency check. Slot 2
// never issues ahead of slot 1. Issue strobes and operand fields are registered and
// routed to the even (ep_*) or odd (op_*) pipe.
//
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   in_valid / in_ready           pair handshake (in_ready is combinational)
//   in_v2                         slot 2 valid
//   in_inst*, in_pipe*            instruction word, target pipe (0 even, 1 odd)
//   in_rt*/ra*/rb*/rc*            register addresses
//   in_src*, in_wr*, in_lat*      source-use mask {ra,rb,rc}, writes rt, result latency
//   flush                         discard held instructions
//   ep_* / op_*                   registered issue strobe and fields per pipe
//   dual_issued                   both pipes issued this cycle
//   stall_cycles, dual_count      performance counters (only with ISSUE_PERF_CNT_EN)
//
// Build option: define ISSUE_PERF_CNT_EN to add the stall/dual-issue counters.

module dual_issue_scheduler #(
    parameter int unsigned NREG = 128,
    parameter int unsigned LATW = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_v2,
    input  logic [31:0]             in_inst1,
    input  logic [31:0]             in_inst2,
    input  logic                    in_pipe1,
    input  logic                    in_pipe2,
    input  logic [$clog2(NREG)-1:0] in_rt1,
    input  logic [$clog2(NREG)-1:0] in_ra1,
    input  logic [$clog2(NREG)-1:0] in_rb1,
    input  logic [$clog2(NREG)-1:0] in_rc1,
    input  logic [$clog2(NREG)-1:0] in_rt2,
    input  logic [$clog2(NREG)-1:0] in_ra2,
    input  logic [$clog2(NREG)-1:0] in_rb2,
    input  logic [$clog2(NREG)-1:0] in_rc2,
    input  logic [2:0]              in_src1,
    input  logic [2:0]              in_src2,
    input  logic                    in_wr1,
    input  logic                    in_wr2,
    input  logic [LATW-1:0]         in_lat1,
    input  logic [LATW-1:0]         in_lat2,
    input  logic                    flush,
    output logic                    ep_issue,
    output logic                    op_issue,
    output logic [31:0]             ep_inst,
    output logic [31:0]             op_inst,
    output logic [$clog2(NREG)-1:0] ep_rt,
    output logic [$clog2(NREG)-1:0] ep_ra,
    output logic [$clog2(NREG)-1:0] ep_rb,
    output logic [$clog2(NREG)-1:0] ep_rc,
    output logic [$clog2(NREG)-1:0] op_rt,
    output logic [$clog2(NREG)-1:0] op_ra,
    output logic [$clog2(NREG)-1:0] op_rb,
    output logic [$clog2(NREG)-1:0] op_rc,
    output logic                    dual_issued
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             dual_count
`endif
);

    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic [1:0] {StEmpty, StHoldBoth, StHoldSecond} state_e;

    typedef struct packed {
        logic [31:0]     inst;
        logic            pipe;
        logic [AW-1:0]   rt;
        logic [AW-1:0]   ra;
        logic [AW-1:0]   rb;
        logic [AW-1:0]   rc;
        logic [2:0]      src;
        logic            wr;
        logic [LATW-1:0] lat;
    } slot_t;

    typedef struct packed {
        logic [31:0]   inst;
        logic [AW-1:0] rt;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] rc;
    } out_t;

    state_e          state_q, state_d;
    slot_t           s1_q, s2_q;
    logic            v2_q;
    logic [LATW-1:0] count_q [NREG];
    logic [LATW-1:0] count_d [NREG];

    logic ep_issue_q, ep_issue_d, op_issue_q, op_issue_d, dual_q;
    out_t ep_q, ep_d, op_q, op_d;

    logic hz1, hz2, dep12, issue1, issue2, all_done, accept;

    // Hazard and issue decision
    always_comb begin
        hz1 = (s1_q.src[2] && count_q[s1_q.ra] != '0) ||
              (s1_q.src[1] && count_q[s1_q.rb] != '0) ||
              (s1_q.src[0] && count_q[s1_q.rc] != '0) ||
              (s1_q.wr     && count_q[s1_q.rt] != '0);
        hz2 = (s2_q.src[2] && count_q[s2_q.ra] != '0) ||
              (s2_q.src[1] && count_q[s2_q.rb] != '0) ||
              (s2_q.src[0] && count_q[s2_q.rc] != '0) ||
              (s2_q.wr     && count_q[s2_q.rt] != '0);
        // Slot 2 depends on slot 1 within the pair; the scoreboard cannot see this yet.
        dep12 = s1_q.wr && ((s2_q.src[2] && s2_q.ra == s1_q.rt) ||
                            (s2_q.src[1] && s2_q.rb == s1_q.rt) ||
                            (s2_q.src[0] && s2_q.rc == s1_q.rt) ||
                            (s2_q.rt == s1_q.rt));

        issue1 = 1'b0;
        issue2 = 1'b0;
        all_done = 1'b0;
        unique case (state_q)
            StEmpty: begin
                all_done = 1'b1;
            end
            StHoldBoth: begin
                issue1 = !hz1 && !flush;
                issue2 = issue1 && v2_q && (s2_q.pipe != s1_q.pipe) && !hz2 && !dep12;
                all_done = issue1 && (!v2_q || issue2);
            end
            StHoldSecond: begin
                issue2 = !hz2 && !flush;
                all_done = issue2;
            end
            default: begin
                all_done = 1'b1;
            end
        endcase

        in_ready = !flush && all_done;
        accept = in_valid && in_ready;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: state_d = StEmpty;
            StHoldBoth: begin
                if (issue1) state_d = (v2_q && !issue2) ? StHoldSecond : StEmpty;
            end
            StHoldSecond: begin
                if (issue2) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
        if (accept) state_d = StHoldBoth;
        if (flush) state_d = StEmpty;
    end

    // Scoreboard. A count is the number of further cycles a reader must wait, so a producer
    // loads lat-1: its dependent then issues exactly lat cycles after the producer's decision.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            count_d[r] = (count_q[r] != '0) ? count_q[r] - LATW'(1) : '0;
            if (issue2 && s2_q.wr && s2_q.rt == AW'(r)) count_d[r] = s2_q.lat - LATW'(1);
            if (issue1 && s1_q.wr && s1_q.rt == AW'(r)) count_d[r] = s1_q.lat - LATW'(1);
        end
    end

    // Output routing; fields hold while the strobe is low
    always_comb begin
        ep_issue_d = 1'b0;
        op_issue_d = 1'b0;
        ep_d = ep_q;
        op_d = op_q;
        if (issue1) begin
            if (s1_q.pipe) begin
                op_issue_d = 1'b1;
                op_d = '{inst: s1_q.inst, rt: s1_q.rt, ra: s1_q.ra, rb: s1_q.rb, rc: s1_q.rc};
            end else begin
                ep_issue_d = 1'b1;
                ep_d = '{inst: s1_q.inst, rt: s1_q.rt, ra: s1_q.ra, rb: s1_q.rb, rc: s1_q.rc};
            end
        end
        // Dual issue only happens with differing pipes, so slot 2 never collides with slot 1.
        if (issue2) begin
            if (s2_q.pipe) begin
                op_issue_d = 1'b1;
                op_d = '{inst: s2_q.inst, rt: s2_q.rt, ra: s2_q.ra, rb: s2_q.rb, rc: s2_q.rc};
            end else begin
                ep_issue_d = 1'b1;
                ep_d = '{inst: s2_q.inst, rt: s2_q.rt, ra: s2_q.ra, rb: s2_q.rb, rc: s2_q.rc};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StEmpty;
            s1_q       <= '0;
            s2_q       <= '0;
            v2_q       <= 1'b0;
            ep_issue_q <= 1'b0;
            op_issue_q <= 1'b0;
            dual_q     <= 1'b0;
            ep_q       <= '0;
            op_q       <= '0;
            for (int unsigned r = 0; r < NREG; r++) count_q[r] <= '0;
        end else begin
            state_q    <= state_d;
            ep_issue_q <= ep_issue_d;
            op_issue_q <= op_issue_d;
            dual_q     <= ep_issue_d && op_issue_d;
            ep_q       <= ep_d;
            op_q       <= op_d;
            for (int unsigned r = 0; r < NREG; r++) count_q[r] <= count_d[r];
            if (accept) begin
                s1_q <= '{inst: in_inst1, pipe: in_pipe1, rt: in_rt1, ra: in_ra1, rb: in_rb1,
                          rc: in_rc1, src: in_src1, wr: in_wr1, lat: in_lat1};
                s2_q <= '{inst: in_inst2, pipe: in_pipe2, rt: in_rt2, ra: in_ra2, rb: in_rb2,
                          rc: in_rc2, src: in_src2, wr: in_wr2, lat: in_lat2};
                v2_q <= in_v2;
            end
        end
    end

    assign ep_issue    = ep_issue_q;
    assign op_issue    = op_issue_q;
    assign dual_issued = dual_q;
    assign ep_inst     = ep_q.inst;
    assign ep_rt       = ep_q.rt;
    assign ep_ra       = ep_q.ra;
    assign ep_rb       = ep_q.rb;
    assign ep_rc       = ep_q.rc;
    assign op_inst     = op_q.inst;
    assign op_rt       = op_q.rt;
    assign op_ra       = op_q.ra;
    assign op_rb       = op_q.rb;
    assign op_rc       = op_q.rc;

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] stall_q, dcnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            dcnt_q  <= '0;
        end else begin
            if (state_q != StEmpty && !issue1 && !issue2) stall_q <= stall_q + 32'd1;
            if (dual_q) dcnt_q <= dcnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign dual_count   = dcnt_q;
`else
    // Performance counters not built.
`endif

endmodule
